// File: rtl/loop_ctrl_pkg.sv
// Shared types for the loop-control arbiters: requester count, grant index
// type, sequencer states and a one-hot helper.
package loop_ctrl_pkg;

  localparam int unsigned NREQ_C = 4;

  typedef logic [$clog2(NREQ_C)-1:0] gnt_id_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP,
    ARB
  } state_t;

  function automatic logic [NREQ_C-1:0] id_onehot(input gnt_id_t id);
    return NREQ_C'(1) << id;
  endfunction

endpackage

// File: rtl/loop_ctrl_arb_if.sv
// Request/grant bundle between the four requesters and the nor4 arbiter.
interface loop_ctrl_arb_if;
  import loop_ctrl_pkg::*;

  logic                en;
  logic [NREQ_C-1:0]   req;
  logic [NREQ_C-1:0]   gnt;
  gnt_id_t             gnt_id;
  logic                busy;
  logic                idle;
  logic                preempt;

  modport master (
    output en, req,
    input  gnt, gnt_id, busy, idle, preempt
  );

  modport slave (
    input  en, req,
    output gnt, gnt_id, busy, idle, preempt
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first active request at or after
// ptr, wrapping around.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] idx;

  // Scan from the farthest offset down to ptr so the nearest request wins.
  always_comb begin
    valid  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(3 - i);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/loop_ctrl_arb.sv
// Round-robin arbiter with break-before-make sequencing for the shared nor4
// datapath: dead gap between grants, forced handoff after MAX_HOLD, and a
// registered "no requester active" flag.
module loop_ctrl_arb
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  loop_ctrl_arb_if.slave bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  gnt_id_t           id_q, id_d;
  gnt_id_t           ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              busy_q, idle_q, preempt_q, preempt_d;

  logic              pick_valid;
  gnt_id_t           pick_id;
  logic [NREQ-1:0]   others;
  logic              hold_full;
  logic              gap_done;
  logic              handoff;
  logic              do_pick;

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign others    = bus.req & ~id_onehot(id_q);
  assign hold_full = (32'(hold_q) == MAX_HOLD);
  assign gap_done  = (32'(gap_q) + 32'd1 >= GAP_CYCLES);

  // Next-state, grant and counter logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    preempt_d = 1'b0;
    handoff   = 1'b0;
    do_pick   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en && pick_valid) do_pick = 1'b1;
      end
      GRANT: begin
        if (!bus.en) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (!bus.req[id_q]) begin
          handoff = 1'b1;
        end else if (hold_full && (|others)) begin
          preempt_d = 1'b1;
          handoff   = 1'b1;
        end else if (!hold_full) begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        if (!bus.en)       state_d = IDLE;
        else if (gap_done) state_d = (|bus.req) ? ARB : IDLE;
        else               gap_d   = gap_q + GW'(1);
      end
      ARB: begin
        if (!bus.en)         state_d = IDLE;
        else if (pick_valid) do_pick = 1'b1;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Without a gap the re-pick happens in the GRANT exit cycle itself; the
    // pointer already sits past the holder, so the picker never returns it.
    if (handoff) begin
      gnt_d = '0;
      if (GAP_CYCLES == 0) begin
        if (pick_valid) do_pick = 1'b1;
        else            state_d = IDLE;
      end else begin
        state_d = GAP;
        gap_d   = '0;
      end
    end

    if (do_pick) begin
      state_d = GRANT;
      gnt_d   = id_onehot(pick_id);
      id_d    = pick_id;
      ptr_d   = pick_id + 2'd1;
      hold_d  = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
      idle_q    <= 1'b1;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      busy_q    <= (state_d != IDLE);
      idle_q    <= (state_d == IDLE) && !(|bus.req);
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = busy_q;
  assign bus.idle    = idle_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_loop_ctrl_arb.sv
// Bench for loop_ctrl_arb: a default build (MAX_HOLD=16, GAP_CYCLES=1) and a
// no-gap build (MAX_HOLD=2, GAP_CYCLES=0) driven by the same inputs, each
// compared every cycle against a behavioural model of the grant rules.
module tb_loop_ctrl_arb;
  import loop_ctrl_pkg::*;

  localparam int MH0 = 16;
  localparam int GC0 = 1;
  localparam int MH1 = 2;
  localparam int GC1 = 0;

  typedef struct {
    int owner;    // current holder, -1 when nobody holds the grant
    int held;     // grant cycles completed by the holder, counting the current one
    int dead;     // handoff cycles still to elapse before a new pick
    int ptr;      // first requester searched on the next pick
    int last_id;
    bit pre;
    bit idl;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;

  int n_tests = 0;
  int n_fail  = 0;

  mstate_t m0, m1;
  int hist0[$], hist1[$];
  int pre0_cnt, pre1_cnt, busy0_low, idle0_hi;

  always #5 clk = ~clk;

  loop_ctrl_arb_if bus0 ();
  loop_ctrl_arb_if bus1 ();

  assign bus0.en  = en;
  assign bus0.req = req;
  assign bus1.en  = en;
  assign bus1.req = req;

  loop_ctrl_arb #(.NREQ(4), .MAX_HOLD(MH0), .GAP_CYCLES(GC0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  loop_ctrl_arb #(.NREQ(4), .MAX_HOLD(MH1), .GAP_CYCLES(GC1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic mstate_t model_init();
    mstate_t s;
    s.owner = -1; s.held = 0; s.dead = 0; s.ptr = 0; s.last_id = 0;
    s.pre = 1'b0; s.idl = 1'b1;
    return s;
  endfunction

  function automatic mstate_t try_grant(mstate_t s, logic [3:0] r);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = (s.ptr + k) % 4;
      if (r[c]) begin
        s.owner = c; s.held = 1; s.last_id = c; s.ptr = (c + 1) % 4;
        return s;
      end
    end
    return s;
  endfunction

  function automatic mstate_t leave(mstate_t s, int gc, logic [3:0] r);
    s.owner = -1;
    if (gc == 0) s = try_grant(s, r);
    else         s.dead = gc + 1;
    return s;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int mh, int gc, logic e, logic [3:0] r);
    logic [3:0] oth;
    s.pre = 1'b0;
    if (!e) begin
      s.owner = -1; s.dead = 0;
    end else if (s.owner >= 0) begin
      oth = r & ~(4'b0001 << s.owner);
      if (!r[s.owner]) s = leave(s, gc, r);
      else if (s.held >= mh + 1 && oth != 4'b0000) begin
        s.pre = 1'b1;
        s = leave(s, gc, r);
      end else s.held++;
    end else if (s.dead > 2) s.dead--;
    else if (s.dead == 2) s.dead = (r == 4'b0000) ? 0 : 1;
    else if (s.dead == 1) begin
      s.dead = 0;
      s = try_grant(s, r);
    end else s = try_grant(s, r);
    s.idl = (s.owner < 0 && s.dead == 0 && r == 4'b0000);
    return s;
  endfunction

  task automatic check_dut(input string p, input mstate_t m, input logic [3:0] g,
                           input logic [1:0] id, input logic b, input logic i, input logic pr);
    check({p, ".gnt"},     32'(g),  (m.owner >= 0) ? (1 << m.owner) : 0);
    check({p, ".gnt_id"},  32'(id), m.last_id);
    check({p, ".busy"},    32'(b),  32'(m.owner >= 0 || m.dead > 0));
    check({p, ".idle"},    32'(i),  32'(m.idl));
    check({p, ".preempt"}, 32'(pr), 32'(m.pre));
  endtask

  task automatic tick();
    logic       e;
    logic [3:0] r;
    e = en;
    r = req;
    @(posedge clk);
    m0 = model_step(m0, MH0, GC0, e, r);
    m1 = model_step(m1, MH1, GC1, e, r);
    #1;
    check_dut("d0", m0, bus0.gnt, bus0.gnt_id, bus0.busy, bus0.idle, bus0.preempt);
    check_dut("d1", m1, bus1.gnt, bus1.gnt_id, bus1.busy, bus1.idle, bus1.preempt);
    hist0.push_back(int'(bus0.gnt));
    hist1.push_back(int'(bus1.gnt));
    if (bus0.preempt) pre0_cnt++;
    if (bus1.preempt) pre1_cnt++;
    if (!bus0.busy)   busy0_low++;
    if (bus0.idle)    idle0_hi++;
  endtask

  task automatic clear_stats();
    hist0.delete();
    hist1.delete();
    pre0_cnt = 0; pre1_cnt = 0; busy0_low = 0; idle0_hi = 0;
  endtask

  task automatic check_reset_values(input string p, input logic [3:0] g, input logic [1:0] id,
                                    input logic b, input logic i, input logic pr);
    check({p, ".rst_gnt"},     32'(g),  0);
    check({p, ".rst_gnt_id"},  32'(id), 0);
    check({p, ".rst_busy"},    32'(b),  0);
    check({p, ".rst_idle"},    32'(i),  1);
    check({p, ".rst_preempt"}, 32'(pr), 0);
  endtask

  initial begin
    int seq[$];
    int run_len;
    int zeros;

    en    = 1'b0;
    req   = 4'b0000;
    rst_n = 1'b0;
    m0    = model_init();
    m1    = model_init();
    clear_stats();

    #12;
    check_reset_values("d0", bus0.gnt, bus0.gnt_id, bus0.busy, bus0.idle, bus0.preempt);
    check_reset_values("d1", bus1.gnt, bus1.gnt_id, bus1.busy, bus1.idle, bus1.preempt);
    rst_n = 1'b1;

    // All four requesting: 0,1,2,3 in turn, each for MAX_HOLD+1 cycles.
    en  = 1'b1;
    req = 4'b1111;
    repeat (76) tick();
    seq.delete();
    run_len = 0;
    for (int k = 0; k < hist0.size(); k++) begin
      if (hist0[k] != 0 && (k == 0 || hist0[k] != hist0[k-1])) seq.push_back(hist0[k]);
      if (hist0[k] == 1 && seq.size() == 1) run_len++;
    end
    check("rr.grants", 32'(seq.size()), 4);
    for (int k = 0; k < 4 && k < seq.size(); k++) check("rr.order", 32'(seq[k]), 32'(1 << k));
    check("rr.hold_len", 32'(run_len), 17);
    check("rr.preempts", 32'(pre0_cnt), 4);
    check("rr.busy_low", 32'(busy0_low), 0);

    // Lone holder keeps the grant indefinitely.
    req = 4'b0000;
    repeat (4) tick();
    clear_stats();
    req = 4'b0100;
    repeat (40) tick();
    zeros = 0;
    foreach (hist0[k]) if (hist0[k] != 4) zeros++;
    check("alone.gnt_other", 32'(zeros), 0);
    check("alone.preempts", 32'(pre0_cnt), 0);
    check("alone.idle_hi", 32'(idle0_hi), 0);

    // Holder 2 releases after 5 cycles with requester 0 waiting.
    req = 4'b0000;
    repeat (4) tick();
    req = 4'b0100;
    tick();
    req = 4'b0101;
    repeat (4) tick();
    req = 4'b0001;
    tick();
    check("rel.gap1", 32'(bus0.gnt), 0);
    tick();
    check("rel.gap2", 32'(bus0.gnt), 0);
    tick();
    check("rel.next_gnt", 32'(bus0.gnt), 1);
    check("rel.next_id", 32'(bus0.gnt_id), 0);

    // en dropped during a grant to requester 1; ptr survives the idle spell.
    req = 4'b0010;
    repeat (3) tick();
    check("en.holder1", 32'(bus0.gnt), 2);
    en = 1'b0;
    tick();
    check("en.off_gnt", 32'(bus0.gnt), 0);
    check("en.off_busy", 32'(bus0.busy), 0);
    en  = 1'b1;
    req = 4'b1111;
    tick();
    check("en.resume", 32'(bus0.gnt), 4);

    // Asynchronous reset while in the gap.
    req = 4'b0000;
    tick();
    check("gap.busy", 32'(bus0.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("d0a", bus0.gnt, bus0.gnt_id, bus0.busy, bus0.idle, bus0.preempt);
    check_reset_values("d1a", bus1.gnt, bus1.gnt_id, bus1.busy, bus1.idle, bus1.preempt);
    m0 = model_init();
    m1 = model_init();
    #1;
    rst_n = 1'b1;
    req   = 4'b1000;
    tick();
    check("rst.first_gnt", 32'(bus0.gnt), 8);

    // No-gap build: direct one-hot to one-hot switching with preemption.
    clear_stats();
    req = 4'b0011;
    repeat (8) tick();
    zeros = 0;
    foreach (hist1[k]) if (hist1[k] == 0) zeros++;
    check("nogap.zero_cycles", 32'(zeros), 0);
    check("nogap.first", 32'(hist1[0]), 1);
    check("nogap.switch", 32'(hist1[3]), 2);
    check("nogap.back", 32'(hist1[6]), 1);
    check("nogap.preempts", 32'(pre1_cnt), 2);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 24) != 0);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
